// File: rtl/puf_eval_pkg.sv
// puf_eval_pkg
//   Shared definitions for the PUF evaluation sequencer:
//   - state_e          : sequencer state encoding (3 bits)
//   - DEFAULT_*        : default parameter values for the sequencer
//   - cnt_width()      : bits needed to hold a count of 0..max_count
package puf_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIGGER   = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_RESULT    = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_RESPONSE_WIDTH = 6;
    localparam int unsigned DEFAULT_NUM_EVALS      = 15;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_GAP_CYCLES     = 4;

    // Never returns 0 so that a zero maximum still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/bit_vote_counter.sv
// bit_vote_counter
//   Tallies how many evaluations returned a 1 on one PUF response bit and
//   reports the majority and instability of that bit.
//   Ports:
//     clk, reset (async, active-low)
//     clear     : zero the tally (takes priority over inc_en)
//     inc_en    : add one to the tally this cycle
//     majority  : 2*tally > NUM_EVALS
//     unstable  : tally neither 0 nor NUM_EVALS (evaluations disagreed)
module bit_vote_counter
    import puf_eval_pkg::*;
#(
    parameter int unsigned NUM_EVALS = DEFAULT_NUM_EVALS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc_en,
    output logic majority,
    output logic unstable
);

    localparam int unsigned CW = cnt_width(NUM_EVALS);
    localparam logic [CW:0]   MAJ_LIMIT = (CW + 1)'(NUM_EVALS);
    localparam logic [CW-1:0] ALL_ONES  = CW'(NUM_EVALS);

    logic [CW-1:0] vote_q;
    logic [CW-1:0] vote_d;
    logic [CW:0]   twice_vote;

    always_comb begin
        vote_d = vote_q;
        if (clear) begin
            vote_d = '0;
        end else if (inc_en) begin
            vote_d = vote_q + CW'(1);
        end
    end

    // Outputs are derived from the next tally so the sample taken on the
    // final puf_done is already included when the parent latches the result.
    always_comb begin
        twice_vote = {vote_d, 1'b0};
        majority   = (twice_vote > MAJ_LIMIT);
        unstable   = (vote_d != '0) && (vote_d != ALL_ONES);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= '0;
        end else begin
            vote_q <= vote_d;
        end
    end

endmodule

// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer
//   Turns one evaluation request into NUM_EVALS trigger/done cycles on the
//   PUF, majority-votes each response bit and flags bits that disagreed.
//   A per-evaluation timeout protects the host from a hung PUF.
//   Ports:
//     clk, reset (async, active-low)
//     req_valid / req_ready          : request handshake (ready only in IDLE)
//     puf_trigger                    : one-cycle start pulse to the PUF
//     puf_done, puf_response         : PUF result, sampled while waiting
//     rsp_valid / rsp_ready          : result handshake, held until accepted
//     rsp_majority, rsp_unstable     : voted response and instability mask
//     rsp_timeout                    : request aborted on a timeout
//     busy                           : any state other than IDLE
module puf_eval_sequencer
    import puf_eval_pkg::*;
#(
    parameter int unsigned RESPONSE_WIDTH = DEFAULT_RESPONSE_WIDTH,
    parameter int unsigned NUM_EVALS      = DEFAULT_NUM_EVALS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic                      puf_trigger,
    input  logic                      puf_done,
    input  logic [RESPONSE_WIDTH-1:0] puf_response,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [RESPONSE_WIDTH-1:0] rsp_majority,
    output logic [RESPONSE_WIDTH-1:0] rsp_unstable,
    output logic                      rsp_timeout,
    output logic                      busy
);

    localparam int unsigned EW = cnt_width(NUM_EVALS);
    localparam int unsigned WW = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);

    localparam logic [EW-1:0] LAST_EVAL   = EW'(NUM_EVALS);
    localparam logic [WW-1:0] TIMEOUT_VAL = WW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_VAL     = GW'(GAP_CYCLES);

    state_e                    state_q, state_d;
    logic [EW-1:0]             eval_cnt_q, eval_cnt_d;
    logic [WW-1:0]             wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic                      req_ready_q, req_ready_d;
    logic                      puf_trigger_q, puf_trigger_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      busy_q, busy_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [RESPONSE_WIDTH-1:0] rsp_majority_q, rsp_majority_d;
    logic [RESPONSE_WIDTH-1:0] rsp_unstable_q, rsp_unstable_d;

    logic                      accept;
    logic                      done_hit;
    logic [WW-1:0]             wait_next;
    logic [RESPONSE_WIDTH-1:0] vote_inc;
    logic [RESPONSE_WIDTH-1:0] bit_majority;
    logic [RESPONSE_WIDTH-1:0] bit_unstable;

    always_comb begin
        accept    = (state_q == ST_IDLE) && req_valid;
        done_hit  = (state_q == ST_WAIT_DONE) && puf_done;
        vote_inc  = done_hit ? puf_response : '0;
        wait_next = wait_cnt_q + WW'(1);
    end

    for (genvar i = 0; i < RESPONSE_WIDTH; i++) begin : g_vote
        bit_vote_counter #(
            .NUM_EVALS (NUM_EVALS)
        ) u_vote (
            .clk      (clk),
            .reset    (reset),
            .clear    (accept),
            .inc_en   (vote_inc[i]),
            .majority (bit_majority[i]),
            .unstable (bit_unstable[i])
        );
    end

    always_comb begin
        state_d        = state_q;
        eval_cnt_d     = eval_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        rsp_timeout_d  = rsp_timeout_q;
        rsp_majority_d = rsp_majority_q;
        rsp_unstable_d = rsp_unstable_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    eval_cnt_d    = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                wait_cnt_d = wait_next;
                // puf_done is checked first so it wins over a coincident timeout.
                if (puf_done) begin
                    eval_cnt_d = eval_cnt_q + EW'(1);
                    if (eval_cnt_d == LAST_EVAL) begin
                        rsp_majority_d = bit_majority;
                        rsp_unstable_d = bit_unstable;
                        state_d        = ST_RESULT;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = ST_TRIGGER;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end else if (wait_next == TIMEOUT_VAL) begin
                    rsp_timeout_d  = 1'b1;
                    rsp_majority_d = '0;
                    rsp_unstable_d = '1;
                    state_d        = ST_RESULT;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_d == GAP_VAL) begin
                    state_d = ST_TRIGGER;
                end
            end
            ST_RESULT: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/status outputs are registered copies of the next state.
        req_ready_d   = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        puf_trigger_d = (state_d == ST_TRIGGER);
        rsp_valid_d   = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            eval_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            puf_trigger_q  <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            rsp_majority_q <= '0;
            rsp_unstable_q <= '0;
        end else begin
            state_q        <= state_d;
            eval_cnt_q     <= eval_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
            puf_trigger_q  <= puf_trigger_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_timeout_q  <= rsp_timeout_d;
            rsp_majority_q <= rsp_majority_d;
            rsp_unstable_q <= rsp_unstable_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign puf_trigger  = puf_trigger_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign rsp_majority = rsp_majority_q;
    assign rsp_unstable = rsp_unstable_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// tb_puf_eval_sequencer
//   Directed sequence of evaluation requests against puf_eval_sequencer with
//   a PUF model driven from per-evaluation response/delay tables.
module tb_puf_eval_sequencer;

    localparam int unsigned RW  = 6;
    localparam int unsigned NE  = 15;
    localparam int unsigned TO  = 20;
    localparam int unsigned GAP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          puf_trigger;
    logic          puf_done;
    logic [RW-1:0] puf_response;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_majority;
    logic [RW-1:0] rsp_unstable;
    logic          rsp_timeout;
    logic          busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned trig_count = 0;

    // Per-evaluation PUF behaviour; delay 0 means the PUF never answers.
    logic [RW-1:0] resp_tab [NE];
    int unsigned   delay_tab [NE];

    puf_eval_sequencer #(
        .RESPONSE_WIDTH (RW),
        .NUM_EVALS      (NE),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .puf_trigger  (puf_trigger),
        .puf_done     (puf_done),
        .puf_response (puf_response),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_majority (rsp_majority),
        .rsp_unstable (rsp_unstable),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (puf_trigger === 1'b1) begin
            trig_count <= trig_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_req_ready"},    32'(req_ready),    32'd1);
        check({name, "_puf_trigger"},  32'(puf_trigger),  32'd0);
        check({name, "_rsp_valid"},    32'(rsp_valid),    32'd0);
        check({name, "_rsp_majority"}, 32'(rsp_majority), 32'd0);
        check({name, "_rsp_unstable"}, 32'(rsp_unstable), 32'd0);
        check({name, "_rsp_timeout"},  32'(rsp_timeout),  32'd0);
        check({name, "_busy"},         32'(busy),         32'd0);
    endtask

    // Reference result: count ones per bit over the answered evaluations.
    task automatic model_result(input int unsigned n_ans, input bit hung,
                                output logic [RW-1:0] m, output logic [RW-1:0] u);
        int unsigned ones;
        for (int unsigned b = 0; b < RW; b++) begin
            ones = 0;
            for (int unsigned e = 0; e < n_ans; e++) begin
                ones += 32'(resp_tab[e][b]);
            end
            m[b] = (ones * 2 > NE);
            u[b] = (ones != 0) && (ones != NE);
        end
        if (hung) begin
            m = '0;
            u = '1;
        end
    endtask

    task automatic fill_const(input logic [RW-1:0] value, input int unsigned d);
        for (int unsigned e = 0; e < NE; e++) begin
            resp_tab[e]  = value;
            delay_tab[e] = d;
        end
    endtask

    task automatic fill_random();
        for (int unsigned e = 0; e < NE; e++) begin
            resp_tab[e]  = RW'($urandom);
            delay_tab[e] = ($urandom_range(3, 0) == 0) ? TO : $urandom_range(TO, 1);
        end
    endtask

    task automatic fill_noisy(input int unsigned k);
        int unsigned j;
        logic [RW-1:0] tmp;
        for (int unsigned e = 0; e < NE; e++) begin
            resp_tab[e]  = (e < k) ? RW'(1) : RW'(0);
            delay_tab[e] = $urandom_range(6, 1);
        end
        for (int unsigned e = NE - 1; e > 0; e--) begin
            j           = $urandom_range(e, 0);
            tmp         = resp_tab[e];
            resp_tab[e] = resp_tab[j];
            resp_tab[j] = tmp;
        end
    endtask

    task automatic wait_trigger(output int unsigned waited, output bit seen);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 60) begin
            @(negedge clk);
            waited++;
            if (puf_trigger === 1'b1) begin
                seen = 1'b1;
            end
        end
    endtask

    // One request; abort_at (1-based evaluation) asserts reset mid-request.
    task automatic run_request(input string name, input int unsigned abort_at,
                               input int unsigned hold);
        int unsigned   trig_base;
        int unsigned   n_ans;
        int unsigned   waited;
        int unsigned   elapsed;
        int unsigned   d;
        bit            seen;
        bit            hung;
        logic [RW-1:0] em;
        logic [RW-1:0] eu;
        n_ans = 0;
        hung  = 1'b0;
        check({name, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        trig_base = trig_count;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_trig_after_accept"}, 32'(puf_trigger), 32'd1);
        for (int unsigned e = 0; e < NE; e++) begin
            @(negedge clk);
            check({name, "_trig_one_cycle"}, 32'(puf_trigger), 32'd0);
            if (abort_at == e + 1) begin
                reset = 1'b0;
                #1;
                check_reset_values({name, "_abort"});
                trig_base = trig_count;
                repeat (3) @(negedge clk);
                reset = 1'b1;
                repeat (30) @(negedge clk);
                check({name, "_no_trig_after_abort"}, trig_count - trig_base, 32'd0);
                check({name, "_idle_after_abort"}, 32'(req_ready), 32'd1);
                return;
            end
            d = delay_tab[e];
            if (d == 0) begin
                elapsed = 1;
                while (rsp_valid !== 1'b1 && elapsed < TO + 40) begin
                    @(negedge clk);
                    elapsed++;
                end
                check({name, "_timeout_latency"}, elapsed, TO + 1);
                hung = 1'b1;
                break;
            end
            repeat (d - 1) @(negedge clk);
            puf_done     = 1'b1;
            puf_response = resp_tab[e];
            @(negedge clk);
            puf_done     = 1'b0;
            puf_response = RW'($urandom);
            n_ans++;
            if (e == NE - 1) begin
                check({name, "_valid_after_last"}, 32'(rsp_valid), 32'd1);
            end else begin
                check({name, "_no_valid_mid"}, 32'(rsp_valid), 32'd0);
                // Stray done and request while in the gap must be ignored.
                puf_done  = 1'($urandom);
                req_valid = 1'($urandom);
                @(negedge clk);
                puf_done  = 1'b0;
                req_valid = 1'b0;
                wait_trigger(waited, seen);
                check({name, "_gap_spacing"}, waited, GAP - 1);
                if (!seen) begin
                    return;
                end
            end
        end
        model_result(n_ans, hung, em, eu);
        check({name, "_rsp_valid"},    32'(rsp_valid),    32'd1);
        check({name, "_rsp_majority"}, 32'(rsp_majority), 32'(em));
        check({name, "_rsp_unstable"}, 32'(rsp_unstable), 32'(eu));
        check({name, "_rsp_timeout"},  32'(rsp_timeout),  32'(hung));
        check({name, "_req_ready_busy"}, 32'(req_ready),  32'd0);
        check({name, "_trigger_count"}, trig_count - trig_base, n_ans + 32'(hung));
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"},    32'(rsp_valid),    32'd1);
            check({name, "_hold_majority"}, 32'(rsp_majority), 32'(em));
            check({name, "_hold_unstable"}, 32'(rsp_unstable), 32'(eu));
            check({name, "_hold_timeout"},  32'(rsp_timeout),  32'(hung));
            check({name, "_hold_req_ready"}, 32'(req_ready),   32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_valid_dropped"}, 32'(rsp_valid), 32'd0);
        check({name, "_req_ready_back"}, 32'(req_ready), 32'd1);
        check({name, "_busy_cleared"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        puf_done     = 1'b0;
        puf_response = '0;
        rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        fill_const(6'b101101, 3);
        run_request("stable", 0, 0);

        fill_noisy(8);
        run_request("noisy8", 0, 0);

        fill_noisy(7);
        run_request("noisy7", 0, 0);

        fill_random();
        for (int unsigned e = 0; e < NE; e++) begin
            delay_tab[e] = TO;
        end
        run_request("race", 0, 0);

        fill_random();
        delay_tab[3] = 0;
        run_request("timeout", 0, 0);

        fill_random();
        run_request("backpressure", 0, 10);

        fill_random();
        run_request("abort", 7, 0);

        fill_random();
        run_request("after_abort", 0, 0);

        for (int unsigned r = 0; r < 4; r++) begin
            fill_random();
            run_request("random", 0, $urandom_range(3, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
